stq_drain: RTL and testbench

- Retires committed stores from the head of the store queue (STQ) and writes them to data memory.
- Owns the STQ head pointer.
- Presents each eligible head entry to memory through a valid/ready request channel, then waits for a write acknowledge.
- Pulses a pop to the STQ when the write is acknowledged, freeing the entry in program order.
- Sits between the STQ storage array and the data-memory/cache write port.

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/stq_drain_if.sv | 28 ++
 rtl/stq_drain_wrap_counter.sv | 32 +++
 rtl/stq_drain.sv | 105 ++++++++++
 tb/tb_stq_drain.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared load/store-unit types: widths, STQ entry layout, STQ index and drain FSM state.
package lsu_pkg;

    localparam int XLEN      = 32;
    localparam int STQ_SIZE  = 16;
    localparam int STQ_IDX_W = $clog2(STQ_SIZE);

    typedef logic [STQ_IDX_W-1:0] stq_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK
    } drain_state_t;

    typedef struct packed {
        logic            valid;
        logic            committed;
        logic            address_valid;
        logic            data_valid;
        logic [XLEN-1:0] address;
        logic [XLEN-1:0] data;
    } store_queue_entry;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/stq_drain_if.sv
// STQ head/pop channel plus the data-memory write request/ack channel.
// master = drain engine, slave = STQ storage and memory port.
interface stq_drain_if;
    import lsu_pkg::*;

    stq_idx_t         stq_head;
    store_queue_entry stq_head_entry;
    logic             stq_pop;
    stq_idx_t         stq_pop_index;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [XLEN-1:0]  mem_req_addr;
    logic [XLEN-1:0]  mem_req_data;
    logic             mem_ack;

    modport master (
        output stq_head, stq_pop, stq_pop_index,
        output mem_req_valid, mem_req_addr, mem_req_data,
        input  stq_head_entry, mem_req_ready, mem_ack
    );

    modport slave (
        input  stq_head, stq_pop, stq_pop_index,
        input  mem_req_valid, mem_req_addr, mem_req_data,
        output stq_head_entry, mem_req_ready, mem_ack
    );

endinterface

// File: rtl/stq_drain_wrap_counter.sv
// Power-of-two ring pointer: increments on inc, wraps naturally at 2^WIDTH.
// Zero latency to value after the edge; no backpressure.
module wrap_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (inc) begin
            value_d = value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/stq_drain.sv
// Retires committed STQ head stores to data memory in order; request 1 cycle after eligibility,
// pop 1 cycle after ack (3-cycle minimum per store); request held stable while mem_req_ready is low.
module stq_drain
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    stq_drain_if.master bus,
    output logic        busy,
    output logic        misaligned_error,
    output logic [31:0] drained_count
);

    drain_state_t    state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            pop_q, pop_d;
    stq_idx_t        pop_idx_q, pop_idx_d;
    logic            mis_q, mis_d;
    logic [31:0]     cnt_q, cnt_d;
    stq_idx_t        head;
    logic            head_eligible;
    logic            ack_fire;

    assign head_eligible = bus.stq_head_entry.valid & bus.stq_head_entry.committed &
                           bus.stq_head_entry.address_valid & bus.stq_head_entry.data_valid;
    assign ack_fire      = (state_q == WAIT_ACK) & bus.mem_ack;

    wrap_counter #(
        .WIDTH (STQ_IDX_W)
    ) u_head (
        .clk   (clk),
        .reset (reset),
        .inc   (ack_fire),
        .value (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (head_eligible)     state_d = REQ;
            REQ:      if (bus.mem_req_ready) state_d = WAIT_ACK;
            WAIT_ACK: if (bus.mem_ack)       state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Only IDLE samples the head entry; REQ/WAIT_ACK run from the latched copy.
    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        mis_d     = mis_q;
        pop_d     = ack_fire;
        pop_idx_d = pop_idx_q;
        cnt_d     = cnt_q;
        if ((state_q == IDLE) && head_eligible) begin
            addr_d = word_align(bus.stq_head_entry.address);
            data_d = bus.stq_head_entry.data;
            if (bus.stq_head_entry.address[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end
        end
        if (ack_fire) begin
            pop_idx_d = head;
            cnt_d     = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            data_q    <= '0;
            mis_q     <= 1'b0;
            pop_q     <= 1'b0;
            pop_idx_q <= '0;
            cnt_q     <= '0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            mis_q     <= mis_d;
            pop_q     <= pop_d;
            pop_idx_q <= pop_idx_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.stq_head      = head;
    assign bus.stq_pop       = pop_q;
    assign bus.stq_pop_index = pop_idx_q;
    assign bus.mem_req_valid = (state_q == REQ);
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_data  = data_q;
    assign busy              = (state_q != IDLE);
    assign misaligned_error  = mis_q;
    assign drained_count     = cnt_q;

endmodule

// File: tb/tb_stq_drain.sv
// Bench for stq_drain: STQ array + memory responder, a store-lifetime model checked every cycle,
// and directed scenarios with literal expectations.
module tb_stq_drain;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic        mis;
    logic [31:0] cnt;

    always #5 clk = ~clk;

    stq_drain_if ifc ();

    stq_drain dut (
        .clk              (clk),
        .reset            (reset),
        .bus              (ifc),
        .busy             (busy),
        .misaligned_error (mis),
        .drained_count    (cnt)
    );

    // STQ storage: main writes entries (bumping wr_gen); a pop frees an entry by catching pop_gen up.
    store_queue_entry stq_arr [STQ_SIZE];
    int               wr_gen  [STQ_SIZE];
    int               pop_gen [STQ_SIZE];
    int               pop_log [$];

    function automatic store_queue_entry visible(input int i);
        store_queue_entry e;
        e       = stq_arr[i];
        e.valid = e.valid && (wr_gen[i] != pop_gen[i]);
        return e;
    endfunction

    always_comb ifc.stq_head_entry = visible(int'(ifc.stq_head));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    int rdy_delay = 0;
    int ack_delay = 1;

    // Model: at most one store alive at a time, retired in program order.
    bit          m_on = 1'b0;
    bit          m_have, m_acc, m_pop, m_mis;
    int          m_cnt, m_pop_idx;
    logic [31:0] m_addr, m_data;

    initial begin
        int rdy_wait;
        int ack_cnt;
        store_queue_entry e;
        rdy_wait = 0;
        ack_cnt  = 0;
        ifc.mem_req_ready = 1'b0;
        ifc.mem_ack       = 1'b0;
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("req_valid", ifc.mem_req_valid, m_have && !m_acc);
                if (m_have && !m_acc) begin
                    chk("req_addr", ifc.mem_req_addr, m_addr);
                    chk("req_data", ifc.mem_req_data, m_data);
                end
                chk("busy", busy, m_have);
                chk("pop", ifc.stq_pop, m_pop);
                if (m_pop) chk("pop_index", ifc.stq_pop_index, m_pop_idx);
                chk("head", ifc.stq_head, m_cnt % STQ_SIZE);
                chk("drained_count", cnt, m_cnt);
                chk("misaligned", mis, m_mis);
            end
            if (ifc.stq_pop === 1'b1) begin
                pop_gen[int'(ifc.stq_pop_index)] = wr_gen[int'(ifc.stq_pop_index)];
                pop_log.push_back(int'(ifc.stq_pop_index));
            end
            ifc.mem_ack = 1'b0;
            if (ack_cnt > 0) begin
                ack_cnt--;
                if (ack_cnt == 0) ifc.mem_ack = 1'b1;
            end
            if (ifc.mem_req_valid === 1'b1) begin
                if (rdy_wait > 0) begin
                    ifc.mem_req_ready = 1'b0;
                    rdy_wait--;
                end else begin
                    ifc.mem_req_ready = 1'b1;
                    ack_cnt = ack_delay;
                end
            end else begin
                ifc.mem_req_ready = 1'b0;
                rdy_wait = rdy_delay;
            end
            if (reset) begin
                m_on = 1'b1; m_cnt = 0; m_mis = 1'b0;
                m_have = 1'b0; m_acc = 1'b0; m_pop = 1'b0;
            end else if (m_on) begin
                m_pop = 1'b0;
                if (!m_have) begin
                    e = visible(m_cnt % STQ_SIZE);
                    if (e.valid && e.committed && e.address_valid && e.data_valid) begin
                        m_have = 1'b1;
                        m_acc  = 1'b0;
                        m_addr = e.address & ~32'h3;
                        m_data = e.data;
                        if (e.address[1:0] != 2'b00) m_mis = 1'b1;
                    end
                end else if (!m_acc) begin
                    if (ifc.mem_req_ready) m_acc = 1'b1;
                end else if (ifc.mem_ack) begin
                    m_pop     = 1'b1;
                    m_pop_idx = m_cnt % STQ_SIZE;
                    m_cnt++;
                    m_have    = 1'b0;
                    m_acc     = 1'b0;
                end
            end
        end
    end

    task automatic put(input int i, input logic [31:0] a, input logic [31:0] d,
                       input logic com, input logic dv);
        stq_arr[i] = '{valid: 1'b1, committed: com, address_valid: 1'b1,
                       data_valid: dv, address: a, data: d};
        wr_gen[i]++;
    endtask

    task automatic wait_cnt(input int target, input int budget);
        for (int i = 0; i < budget && cnt != target; i++) @(negedge clk);
        chk($sformatf("drain_to_%0d", target), cnt, target);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, ifc.mem_req_valid, 0);
        chk({tag, "_addr"}, ifc.mem_req_addr, 0);
        chk({tag, "_data"}, ifc.mem_req_data, 0);
        chk({tag, "_pop"}, ifc.stq_pop, 0);
        chk({tag, "_pop_idx"}, ifc.stq_pop_index, 0);
        chk({tag, "_head"}, ifc.stq_head, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mis"}, mis, 0);
        chk({tag, "_cnt"}, cnt, 0);
    endtask

    initial begin
        int  nvalid;
        int  base;
        bit  found;
        for (int i = 0; i < STQ_SIZE; i++) stq_arr[i] = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Single store: eligible at t, request at t+1, ack t+2, pop t+3.
        put(0, 32'h100, 32'hDEADBEEF, 1'b1, 1'b1);
        @(negedge clk); chk("s_t0_valid", ifc.mem_req_valid, 0);
        @(negedge clk); chk("s_t1_valid", ifc.mem_req_valid, 1);
        chk("s_t1_addr", ifc.mem_req_addr, 32'h100);
        chk("s_t1_data", ifc.mem_req_data, 32'hDEADBEEF);
        @(negedge clk); chk("s_t2_valid", ifc.mem_req_valid, 0);
        chk("s_t2_busy", busy, 1);
        @(negedge clk); chk("s_t3_pop", ifc.stq_pop, 1);
        chk("s_t3_pop_idx", ifc.stq_pop_index, 0);
        chk("s_t3_head", ifc.stq_head, 1);
        chk("s_t3_cnt", cnt, 1);

        // Backpressure: ready low for 4 cycles of valid.
        @(posedge clk); #1 rdy_delay = 4;
        put(1, 32'h104, 32'h11112222, 1'b1, 1'b1);
        nvalid = 0;
        for (int i = 0; i < 40 && cnt != 2; i++) begin
            @(negedge clk);
            if (ifc.mem_req_valid) nvalid++;
        end
        chk("bp_valid_cycles", nvalid, 5);
        chk("bp_drained", cnt, 2);
        chk("bp_pops", pop_log.size(), 2);
        rdy_delay = 0;

        // Uncommitted head stays idle, then requests one cycle after commit.
        @(posedge clk); #1 put(2, 32'h180, 32'h0BADF00D, 1'b0, 1'b1);
        repeat (10) begin
            @(negedge clk); chk("uncommitted_no_req", ifc.mem_req_valid, 0);
        end
        @(posedge clk); #1 stq_arr[2].committed = 1'b1;
        @(negedge clk); chk("commit_t0_valid", ifc.mem_req_valid, 0);
        @(negedge clk); chk("commit_t1_valid", ifc.mem_req_valid, 1);
        chk("commit_t1_addr", ifc.mem_req_addr, 32'h180);
        wait_cnt(3, 20);

        // Misaligned store, gated first by data_valid.
        @(posedge clk); #1 put(3, 32'h203, 32'hCAFEF00D, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_data_idle", busy, 0);
        @(posedge clk); #1 stq_arr[3].data_valid = 1'b1;
        @(negedge clk);
        @(negedge clk); chk("mis_req_valid", ifc.mem_req_valid, 1);
        chk("mis_req_addr", ifc.mem_req_addr, 32'h200);
        wait_cnt(4, 20);
        chk("mis_set", mis, 1);
        @(posedge clk); #1 put(4, 32'h300, 32'h12345678, 1'b1, 1'b1);
        wait_cnt(5, 20);
        chk("mis_sticky", mis, 1);

        // Reset while waiting for ack; the late ack must be ignored.
        @(posedge clk); #1 ack_delay = 4;
        put(5, 32'h400, 32'h55AA55AA, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (busy && !ifc.mem_req_valid) found = 1'b1;
        end
        chk("reached_wait_ack", found, 1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("midrst");
        repeat (6) begin
            @(negedge clk);
            chk("midrst_no_pop", ifc.stq_pop, 0);
            chk("midrst_head", ifc.stq_head, 0);
        end
        stq_arr[5].valid = 1'b0;
        ack_delay = 1;

        // Wrap: 17 back-to-back stores through a full 16-entry ring.
        @(posedge clk); #1 base = pop_log.size();
        for (int i = 0; i < STQ_SIZE; i++) put(i, 32'h1000 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b1, 1'b1);
        wait_cnt(1, 20);
        @(posedge clk); #1 put(0, 32'h1040, 32'hA0000010, 1'b1, 1'b1);
        wait_cnt(17, 200);
        chk("wrap_head", ifc.stq_head, 1);
        chk("wrap_pops", pop_log.size() - base, 17);
        for (int i = 0; i < 17 && base + i < pop_log.size(); i++)
            chk($sformatf("wrap_pop_%0d", i), pop_log[base + i], i % STQ_SIZE);
        repeat (5) @(negedge clk);
        chk("wrap_idle_after", busy, 0);
        chk("wrap_mis_clear", mis, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
